// File: rtl/spi_mem_responder.sv
// spi_mem_responder
//   SPI mode-0 target that fronts a small byte array. It understands two
//   commands: 0x03 (read) and 0x02 (write), each followed by a 24-bit address.
//   Both commands stream any number of bytes, and the address pointer wraps
//   modulo MEM_BYTES. sclk, mosi and cs_n come from the same clock domain as
//   clk, so they pass through a single register stage with no synchronizer.
// Ports
//   clk        system clock (also clocks the SPI initiator)
//   rst_n      asynchronous active-low reset; also clears the array
//   sclk       SPI clock, idle low
//   mosi       serial data in, MSB first
//   cs_n       active-low chip select
//   miso       serial data out, MSB first, registered
//   busy       high whenever the FSM is not in IDLE
//   wr_pulse   one-clk strobe for each byte committed to the array
//   peek_addr  debug read address
//   peek_data  combinational array[peek_addr]
//
// state  | meaning
// IDLE   | waiting for a registered cs_n falling edge
// CMD    | shifting in the command byte
// ADDR   | shifting in three address bytes; the low bits form the pointer
// READ   | streaming array bytes out on miso
// WRITE  | assembling bytes from mosi and committing them to the array
// IGNORE | unknown command; stay quiet until cs_n rises
module spi_mem_responder #(
  parameter int MEM_BYTES = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sclk,
  input  logic                         mosi,
  input  logic                         cs_n,
  output logic                         miso,
  output logic                         busy,
  output logic                         wr_pulse,
  input  logic [$clog2(MEM_BYTES)-1:0] peek_addr,
  output logic [7:0]                   peek_data
);

  localparam int AW = $clog2(MEM_BYTES);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, WRITE, IGNORE} state_t;

  state_t          state, state_next;
  logic            sclk_q, sclk_prev, mosi_q, cs_q, cs_prev;
  logic [2:0]      bit_cnt;
  logic [1:0]      byte_cnt;
  logic [7:0]      rx_shift, tx_shift;
  logic [AW-1:0]   ptr;
  logic            cmd_rd;
  logic [7:0]      mem [MEM_BYTES];

  logic            rise, fall, cs_fall, bit_last;
  logic [7:0]      rx_byte;
  logic [AW-1:0]   ptr_in, ptr_inc;

  assign rise     = sclk_q & ~sclk_prev;
  assign fall     = ~sclk_q & sclk_prev;
  assign cs_fall  = cs_prev & ~cs_q;
  assign bit_last = (bit_cnt == 3'd7);
  assign rx_byte  = {rx_shift[6:0], mosi_q};
  // Address bits shift straight into the pointer; the upper bits fall off the top.
  assign ptr_in   = (ptr << 1) | AW'(mosi_q);
  assign ptr_inc  = ptr + AW'(1);

  assign busy      = (state != IDLE);
  assign peek_data = mem[peek_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (cs_fall) state_next = CMD;
      CMD: begin
        if (cs_q) state_next = IDLE;
        else if (rise && bit_last)
          state_next = (rx_byte == 8'h03 || rx_byte == 8'h02) ? ADDR : IGNORE;
      end
      ADDR: begin
        if (cs_q) state_next = IDLE;
        else if (rise && bit_last && byte_cnt == 2'd2)
          state_next = cmd_rd ? READ : WRITE;
      end
      READ, WRITE, IGNORE: if (cs_q) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q    <= 1'b0;
      sclk_prev <= 1'b0;
      mosi_q    <= 1'b0;
      // Registered cs_n resets low so that a select already held low across
      // reset release does not look like a fresh falling edge.
      cs_q      <= 1'b0;
      cs_prev   <= 1'b0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      ptr       <= '0;
      cmd_rd    <= 1'b0;
      miso      <= 1'b0;
      wr_pulse  <= 1'b0;
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= '0;
    end else begin
      sclk_q    <= sclk;
      sclk_prev <= sclk_q;
      mosi_q    <= mosi;
      cs_q      <= cs_n;
      cs_prev   <= cs_q;
      wr_pulse  <= 1'b0;
      case (state)
        IDLE: begin
          miso <= 1'b0;
          if (cs_fall) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
          end
        end
        CMD: begin
          miso <= 1'b0;
          if (rise && !cs_q) begin
            rx_shift <= rx_byte;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_last) cmd_rd <= (rx_byte == 8'h03);
          end
        end
        ADDR: begin
          miso <= 1'b0;
          if (rise && !cs_q) begin
            ptr     <= ptr_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_last) begin
              byte_cnt <= byte_cnt + 2'd1;
              // Only the load after the final address byte matters.
              tx_shift <= mem[ptr_in];
            end
          end
        end
        READ: begin
          if (cs_q) miso <= 1'b0;
          else if (fall) begin
            // The first fall after the address puts bit 7 out ahead of the
            // initiator's next sampling edge.
            miso    <= tx_shift[7];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_last) begin
              ptr      <= ptr_inc;
              tx_shift <= mem[ptr_inc];
            end else begin
              tx_shift <= {tx_shift[6:0], 1'b0};
            end
          end
        end
        WRITE: begin
          miso <= 1'b0;
          // No cs_q gate here: when the 8th rise and the cs_n rise land in the
          // same clk, the byte still commits before the FSM drops to IDLE.
          if (rise) begin
            rx_shift <= rx_byte;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_last) begin
              mem[ptr] <= rx_byte;
              wr_pulse <= 1'b1;
              ptr      <= ptr_inc;
            end
          end
        end
        default: miso <= 1'b0;
      endcase
    end
  end

endmodule
